// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 8-stage pipelined floating-point add/subtract, round-to-nearest-even, valid/tag sideband, global stall.
// Define FP_ADDSUB_NAN_EN to decode NaNs and return a canonical quiet NaN; otherwise all-ones exponents are infinities.
module fp_addsub_pipe #(
   parameter int EXP_W  = 6,
   parameter int FRAC_W = 14,
   parameter int TAG_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic                  op,
   input  logic [EXP_W+FRAC_W:0] a,
   input  logic [EXP_W+FRAC_W:0] b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   output logic [EXP_W+FRAC_W:0] y,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_ovf,
   output logic                  out_inexact
);
   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int M  = FRAC_W + 1;
   localparam int AW = FRAC_W + 4;
   localparam int XW = EXP_W + 2;
   localparam int LW = $clog2(AW + 1);
   localparam logic [EXP_W-1:0] EONES = '1;

   logic              w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_swap, w_sp;
   logic [EXP_W-1:0]  w_ea, w_eb;
   logic [FRAC_W-1:0] w_fa, w_fb;
   logic [W-1:0]      w_spy;

   logic              r1_s, r1_sub;
   logic [EXP_W-1:0]  r1_eb, r1_es;
   logic [M-1:0]      r1_mb, r1_ms;

   logic [EXP_W-1:0]  w_d;
   logic [AW-1:0]     w_ext, w_sh;
   logic              w_lost;
   logic              r2_s, r2_sub;
   logic [EXP_W-1:0]  r2_e;
   logic [AW-1:0]     r2_mb, r2_ma;

   logic [AW:0]       w_sum;
   logic              r3_s;
   logic [EXP_W-1:0]  r3_e;
   logic [AW:0]       r3_sum;

   logic [LW-1:0]     w_lz;
   logic              r4_s;
   logic [EXP_W-1:0]  r4_e;
   logic [AW:0]       r4_sum;
   logic [LW-1:0]     r4_lz;

   logic              w_c;
   logic [AW-1:0]     w_n;
   logic [XW-1:0]     w_ne;
   logic              r5_s, r5_z;
   logic [XW-1:0]     r5_e;
   logic [AW-2:0]     r5_n;

   logic              r6_s, r6_z, r6_rup, r6_inx;
   logic [XW-1:0]     r6_e;
   logic [FRAC_W-1:0] r6_m;

   logic [FRAC_W:0]   w_m2;
   logic              r7_s, r7_z, r7_uf, r7_inx;
   logic [XW-1:0]     r7_e;
   logic [FRAC_W-1:0] r7_f;

   logic              w_of, w_ovf, w_inx;
   logic [W-1:0]      w_y;

   logic              r_v   [0:6];
   logic [TAG_W-1:0]  r_t   [0:6];
   logic              r_sp  [0:6];
   logic [W-1:0]      r_spy [0:6];

   assign w_sa = a[W-1];
   assign w_sb = b[W-1] ^ op;
   assign w_ea = a[W-2:FRAC_W];
   assign w_eb = b[W-2:FRAC_W];
   assign w_fa = a[FRAC_W-1:0];
   assign w_fb = b[FRAC_W-1:0];
   assign w_za = w_ea == '0;
   assign w_zb = w_eb == '0;
   assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};

`ifdef FP_ADDSUB_NAN_EN
   logic w_nan;
   assign w_ia  = (&w_ea) & ~(|w_fa);
   assign w_ib  = (&w_eb) & ~(|w_fb);
   assign w_nan = ((&w_ea) & (|w_fa)) | ((&w_eb) & (|w_fb)) | (w_ia & w_ib & (w_sa ^ w_sb));
   assign w_sp  = w_nan | w_ia | w_ib | w_za | w_zb;
`else
   assign w_ia = &w_ea;
   assign w_ib = &w_eb;
   assign w_sp = w_ia | w_ib | w_za | w_zb;
`endif

   // Special results bypass the arithmetic stages; opposite-sign inf+inf resolves to +inf via the AND of signs.
   assign w_spy =
`ifdef FP_ADDSUB_NAN_EN
      w_nan           ? {1'b0, EONES, 1'b1, {(FRAC_W-1){1'b0}}} :
`endif
      (w_ia & w_ib)   ? {w_sa & w_sb, EONES, {FRAC_W{1'b0}}} :
      w_ia            ? {w_sa, EONES, {FRAC_W{1'b0}}} :
      w_ib            ? {w_sb, EONES, {FRAC_W{1'b0}}} :
      (w_za & w_zb)   ? {w_sa & w_sb, {(W-1){1'b0}}} :
      w_za            ? {w_sb, b[W-2:0]} : {w_sa, a[W-2:0]};

   assign w_d    = r1_eb - r1_es;
   assign w_ext  = {r1_ms, 3'b000};
   assign w_sh   = w_ext >> w_d;
   assign w_lost = |(w_ext & ~({AW{1'b1}} << w_d));

   assign w_sum = r2_sub ? {1'b0, r2_mb} - {1'b0, r2_ma} : {1'b0, r2_mb} + {1'b0, r2_ma};

   always_comb begin
      w_lz = LW'(AW);
      for (int i = 0; i < AW; i++) if (r3_sum[i]) w_lz = LW'(AW - 1 - i);
   end

   assign w_c  = r4_sum[AW];
   assign w_n  = w_c ? {r4_sum[AW:2], |r4_sum[1:0]} : r4_sum[AW-1:0] << r4_lz;
   assign w_ne = w_c ? XW'(r4_e) + XW'(1) : XW'(r4_e) - XW'(r4_lz);

   // Rounding carry out of the stored fraction leaves it all-zero, so only the exponent needs bumping.
   assign w_m2 = {1'b0, r6_m} + {{FRAC_W{1'b0}}, r6_rup};

   assign w_of  = ~r7_e[XW-1] & (r7_e >= {2'b00, EONES});
   assign w_y   = r_sp[6] ? r_spy[6] :
                  r7_z    ? '0 :
                  r7_uf   ? {r7_s, {(W-1){1'b0}}} :
                  w_of    ? {r7_s, EONES, {FRAC_W{1'b0}}} : {r7_s, r7_e[EXP_W-1:0], r7_f};
   assign w_ovf = ~r_sp[6] & ~r7_z & ~r7_uf & w_of;
   assign w_inx = ~r_sp[6] & ~r7_z & (r7_uf | w_of | r7_inx);

   always_ff @(posedge clk) begin
      if (en) begin
         r1_s   <= w_swap ? w_sb : w_sa;
         r1_sub <= w_sa ^ w_sb;
         r1_eb  <= w_swap ? w_eb : w_ea;
         r1_es  <= w_swap ? w_ea : w_eb;
         r1_mb  <= {1'b1, w_swap ? w_fb : w_fa};
         r1_ms  <= {1'b1, w_swap ? w_fa : w_fb};
         r2_s   <= r1_s;
         r2_sub <= r1_sub;
         r2_e   <= r1_eb;
         r2_mb  <= {r1_mb, 3'b000};
         r2_ma  <= {w_sh[AW-1:1], w_sh[0] | w_lost};
         r3_s   <= r2_s;
         r3_e   <= r2_e;
         r3_sum <= w_sum;
         r4_s   <= r3_s;
         r4_e   <= r3_e;
         r4_sum <= r3_sum;
         r4_lz  <= w_lz;
         r5_s   <= r4_s;
         r5_e   <= w_ne;
         r5_n   <= w_n[AW-2:0];
         r5_z   <= ~w_n[AW-1];
         r6_s   <= r5_s;
         r6_z   <= r5_z;
         r6_e   <= r5_e;
         r6_m   <= r5_n[AW-2:3];
         r6_rup <= r5_n[2] & (r5_n[1] | r5_n[0] | r5_n[3]);
         r6_inx <= |r5_n[2:0];
         r7_s   <= r6_s;
         r7_z   <= r6_z;
         r7_uf  <= r6_e[XW-1] | (r6_e == '0);
         r7_e   <= r6_e + XW'(w_m2[FRAC_W]);
         r7_f   <= w_m2[FRAC_W-1:0];
         r7_inx <= r6_inx;
         r_sp[0]  <= w_sp;
         r_spy[0] <= w_spy;
         for (int i = 1; i < 7; i++) begin
            r_sp[i]  <= r_sp[i-1];
            r_spy[i] <= r_spy[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) begin
            r_v[i] <= 1'b0;
            r_t[i] <= '0;
         end
         out_valid   <= 1'b0;
         out_tag     <= '0;
         y           <= '0;
         out_ovf     <= 1'b0;
         out_inexact <= 1'b0;
      end else if (en) begin
         r_v[0] <= in_valid;
         r_t[0] <= in_tag;
         for (int i = 1; i < 7; i++) begin
            r_v[i] <= r_v[i-1];
            r_t[i] <= r_t[i-1];
         end
         out_valid   <= r_v[6];
         out_tag     <= r_t[6];
         y           <= w_y;
         out_ovf     <= w_ovf;
         out_inexact <= w_inx;
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for fp_addsub_pipe with a latency-aligned expectation delay line.
module tb_fp_addsub_pipe;
   localparam int W = 21;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         in_valid = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [7:0]   in_tag = '0;
   logic         out_valid, out_ovf, out_inexact;
   logic [W-1:0] y;
   logic [7:0]   out_tag;

   int n_cmp = 0;
   int n_bad = 0;

   // {a, op, b, expected y, expected ovf, expected inexact}
   logic [65:0] vec [0:19] = '{
      {21'h07C000, 1'b0, 21'h07C000, 21'h080000, 1'b0, 1'b0},
      {21'h07C000, 1'b1, 21'h07C000, 21'h000000, 1'b0, 1'b0},
      {21'h17C000, 1'b0, 21'h100000, 21'h17C000, 1'b0, 1'b0},
      {21'h07C000, 1'b0, 21'h040000, 21'h07C000, 1'b0, 1'b1},
      {21'h07C001, 1'b0, 21'h040000, 21'h07C002, 1'b0, 1'b1},
      {21'h0FBFFF, 1'b0, 21'h0FBFFF, 21'h0FC000, 1'b1, 1'b1},
      {21'h07C000, 1'b0, 21'h080000, 21'h082000, 1'b0, 1'b0},
      {21'h080000, 1'b1, 21'h07C000, 21'h07C000, 1'b0, 1'b0},
      {21'h07C000, 1'b1, 21'h080000, 21'h17C000, 1'b0, 1'b0},
      {21'h07E000, 1'b0, 21'h07E000, 21'h082000, 1'b0, 1'b0},
      {21'h084000, 1'b0, 21'h07C000, 21'h085000, 1'b0, 1'b0},
      {21'h100000, 1'b0, 21'h100000, 21'h100000, 1'b0, 1'b0},
      {21'h000000, 1'b1, 21'h000000, 21'h000000, 1'b0, 1'b0},
      {21'h000000, 1'b1, 21'h07C000, 21'h17C000, 1'b0, 1'b0},
      {21'h0FC000, 1'b0, 21'h07C000, 21'h0FC000, 1'b0, 1'b0},
      {21'h0FC000, 1'b0, 21'h1FC000, 21'h0FC000, 1'b0, 1'b0},
      {21'h1FC000, 1'b0, 21'h1FC000, 21'h1FC000, 1'b0, 1'b0},
      {21'h004001, 1'b1, 21'h004000, 21'h000000, 1'b0, 1'b1},
      {21'h082000, 1'b1, 21'h07E000, 21'h07E000, 1'b0, 1'b0},
      {21'h07C000, 1'b0, 21'h02C000, 21'h07C000, 1'b0, 1'b1}
   };

   logic [31:0]  gap = 32'h0000_8264;
   logic         ev [0:7];
   logic [W-1:0] ey [0:7];
   logic [7:0]   et [0:7];
   logic         eo [0:7];
   logic         ei [0:7];

   always #5 clk = ~clk;

   fp_addsub_pipe #(.EXP_W(6), .FRAC_W(14), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .op(op), .a(a), .b(b), .in_tag(in_tag),
      .out_valid(out_valid), .y(y), .out_tag(out_tag), .out_ovf(out_ovf), .out_inexact(out_inexact)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         ev[i] = 1'b0;
         ey[i] = '0;
         et[i] = '0;
         eo[i] = 1'b0;
         ei[i] = 1'b0;
      end
   endtask

   task automatic step(input logic e, input logic v, input int k, input logic [7:0] t);
      logic [W-1:0] xy;
      logic         xo, xi;
      {a, op, b, xy, xo, xi} = vec[k];
      en = e;
      in_valid = v;
      in_tag = t;
      @(posedge clk);
      if (e) begin
         for (int i = 7; i > 0; i--) begin
            ev[i] = ev[i-1];
            ey[i] = ey[i-1];
            et[i] = et[i-1];
            eo[i] = eo[i-1];
            ei[i] = ei[i-1];
         end
         ev[0] = v;
         ey[0] = xy;
         et[0] = t;
         eo[0] = xo;
         ei[0] = xi;
      end
      #1;
      chk("out_valid", out_valid, ev[7]);
      if (ev[7]) begin
         chk("y", y, ey[7]);
         chk("out_tag", out_tag, et[7]);
         chk("out_ovf", out_ovf, eo[7]);
         chk("out_inexact", out_inexact, ei[7]);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out_valid"}, out_valid, 0);
      chk({tag, " y"}, y, 0);
      chk({tag, " out_tag"}, out_tag, 0);
      chk({tag, " out_ovf"}, out_ovf, 0);
      chk({tag, " out_inexact"}, out_inexact, 0);
   endtask

   initial begin
      int k;
      int c;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 1'b1, 0, 8'h11);
      repeat (7) step(1'b1, 1'b0, 0, 8'h00);

      k = 0;
      c = 0;
      while (k < 20) begin
         if (c == 12) repeat (3) step(1'b0, 1'b1, 19, 8'hEE);
         if (gap[c]) step(1'b1, 1'b0, 0, 8'h00);
         else begin
            step(1'b1, 1'b1, k, 8'(64 + k));
            k++;
         end
         c++;
      end
      repeat (8) step(1'b1, 1'b0, 0, 8'h00);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 14 + i, 8'(128 + i));
      repeat (2) step(1'b1, 1'b0, 0, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3 + i, 8'(144 + i));
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 5, 8'hA5);
      repeat (7) step(1'b1, 1'b0, 0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
